// File: rtl/decimal_pkg.sv
// Shared decimal digit types, constants and the binary-to-one-hot decode,
// reused by the encoder side for checking.
package decimal_pkg;

  localparam int unsigned DEC_W   = 10;
  localparam int unsigned BIN_W   = 4;
  localparam int unsigned DEC_MAX = 9;

  typedef logic [DEC_W-1:0] dec_onehot_t;
  typedef logic [BIN_W-1:0] bin_digit_t;

  function automatic logic is_out_of_range(input bin_digit_t bin);
    return bin > BIN_W'(DEC_MAX);
  endfunction

  // Codes 10..15 have no decimal digit and decode to all zeros.
  function automatic dec_onehot_t bin2onehot(input bin_digit_t bin);
    if (is_out_of_range(bin)) return '0;
    return dec_onehot_t'(1) << bin;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth, wrapping pointers and an
// occupancy count one bit wider than the pointers.
module sync_fifo #(
  parameter  int unsigned WIDTH = 11,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the blocks are evaluated.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; a slot is only read
  // after it has been written, and the consumer masks the head while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/binary2decimal_decoder.sv
// Streaming 4-bit code to one-hot decimal decoder with an elastic output
// FIFO and a saturating count of out-of-range codes.
module binary2decimal_decoder
  import decimal_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_bin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [9:0]           out_dec,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_clr
);

  localparam int unsigned ENTRY_W = DEC_W + 1;
  localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;

  dec_onehot_t        in_dec;
  logic               in_err;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;

  assign in_dec = bin2onehot(in_bin);
  assign in_err = is_out_of_range(in_bin);

  // Readiness comes only from registered occupancy, never from out_ready.
  assign in_ready  = (fifo_count < CW'(FIFO_DEPTH));
  assign out_valid = !fifo_empty;
  assign push      = in_valid && !fifo_full;
  assign pop       = out_valid && out_ready;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({in_dec, in_err}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // NOTE: outputs get defaults before the conditional so no latch is inferred.
  always_comb begin
    out_dec = '0;
    out_err = 1'b0;
    if (!fifo_empty) {out_dec, out_err} = fifo_rdata;
  end

  // A clear wins over a same-cycle error; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      err_cnt <= '0;
    end else if (push && in_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_binary2decimal_decoder.sv
// Directed and randomised checks of the decoder; a second instance with a
// 2-bit error counter shares the stimulus to exercise saturation.
module tb_binary2decimal_decoder;
  import decimal_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_bin;
  logic       out_ready;
  logic       err_clr;

  logic       in_ready,  out_valid,  out_err;
  logic [9:0] out_dec;
  logic [7:0] err_cnt;
  logic       in_ready_sat, out_valid_sat, out_err_sat;
  logic [9:0] out_dec_sat;
  logic [1:0] err_cnt_sat;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  binary2decimal_decoder #(.FIFO_DEPTH(DEPTH), .ERR_CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_bin(in_bin), .out_valid(out_valid), .out_ready(out_ready),
    .out_dec(out_dec), .out_err(out_err), .err_cnt(err_cnt), .err_clr(err_clr)
  );

  binary2decimal_decoder #(.FIFO_DEPTH(DEPTH), .ERR_CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_sat),
    .in_bin(in_bin), .out_valid(out_valid_sat), .out_ready(out_ready),
    .out_dec(out_dec_sat), .out_err(out_err_sat), .err_cnt(err_cnt_sat),
    .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream obligation: a stalled code must not change.
  assert property (@(posedge clk) disable iff (rst)
                   (in_valid && !in_ready) |=> $stable(in_bin))
    else $error("in_bin changed while stalled");

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [9:0] ramp_dec [10] = '{10'h001, 10'h002, 10'h004, 10'h008, 10'h010,
                                10'h020, 10'h040, 10'h080, 10'h100, 10'h200};
  logic [3:0] bad_bin  [3]  = '{4'd10, 4'd15, 4'd9};
  logic [9:0] bad_dec  [3]  = '{10'h000, 10'h000, 10'h200};
  logic       bad_err  [3]  = '{1'b1, 1'b1, 1'b0};
  logic [1:0] sat_cnt  [5]  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  bin_digit_t  sb_q[$];
  int unsigned m_err, m_err_sat;
  logic        push_will, pop_will, pending;
  bin_digit_t  head;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bin = '0; out_ready = 1'b1; err_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_dec",   out_dec,   0);
    check("rst_out_err",   out_err,   0);
    check("rst_err_cnt",   err_cnt,   0);
    check("rst_in_ready",  in_ready,  1);

    // Codes 0..9 streamed back to back.
    for (int i = 0; i < 10; i++) begin
      in_bin = 4'(i); in_valid = 1'b1;
      tick();
      check("ramp_valid", out_valid,   1);
      check("ramp_dec",   out_dec,     ramp_dec[i]);
      check("ramp_err",   out_err,     0);
      check("ramp_ready", in_ready,    1);
    end
    in_valid = 1'b0;
    tick();
    check("ramp_drained", out_valid, 0);
    check("ramp_errcnt",  err_cnt,   0);

    // Back-pressure: 3 and 7 fill the FIFO, 5 waits.
    out_ready = 1'b0; in_valid = 1'b1; in_bin = 4'd3;
    tick();
    check("bp_dec_3",    out_dec,  10'h008);
    check("bp_ready_1",  in_ready, 1);
    in_bin = 4'd7;
    tick();
    check("bp_full",     in_ready, 0);
    check("bp_hold_a",   out_dec,  10'h008);
    in_bin = 4'd5;
    tick();
    check("bp_stall",    in_ready, 0);
    check("bp_hold_b",   out_dec,  10'h008);
    check("bp_valid",    out_valid, 1);
    out_ready = 1'b1;
    tick();
    check("bp_dec_7",    out_dec,  10'h080);
    check("bp_ready_2",  in_ready, 1);
    tick();
    check("bp_dec_5",    out_dec,  10'h020);
    in_valid = 1'b0;
    tick();
    check("bp_drained",  out_valid, 0);

    // Out-of-range codes pass through flagged.
    for (int i = 0; i < 3; i++) begin
      in_bin = bad_bin[i]; in_valid = 1'b1;
      tick();
      check("oor_dec", out_dec, bad_dec[i]);
      check("oor_err", out_err, bad_err[i]);
    end
    in_valid = 1'b0;
    tick();
    check("oor_errcnt",     err_cnt,     2);
    check("oor_errcnt_sat", err_cnt_sat, 2);

    // Saturation on the 2-bit counter, then clear beating an increment.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_errcnt",     err_cnt,     0);
    check("clr_errcnt_sat", err_cnt_sat, 0);
    for (int i = 0; i < 5; i++) begin
      in_bin = 4'd12; in_valid = 1'b1;
      tick();
      check("sat_cnt",   err_cnt_sat,   sat_cnt[i]);
      check("sat_dec",   out_dec_sat,   0);
      check("sat_err",   out_err_sat,   1);
      check("sat_valid", out_valid_sat, 1);
      check("sat_ready", in_ready_sat,  1);
    end
    check("sat_wide_cnt", err_cnt, 5);
    err_clr = 1'b1;
    tick();
    check("clr_prio_sat", err_cnt_sat, 0);
    check("clr_prio",     err_cnt,     0);
    err_clr = 1'b0; in_valid = 1'b0;
    tick();

    // Reset while full and while being offered data.
    out_ready = 1'b0; in_valid = 1'b1; in_bin = 4'd11;
    tick();
    in_bin = 4'd13;
    tick();
    check("fill_full",   in_ready, 0);
    check("fill_errcnt", err_cnt,  2);
    check("fill_valid",  out_valid, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_valid",  out_valid, 0);
    check("mid_rst_ready",  in_ready,  1);
    check("mid_rst_errcnt", err_cnt,   0);
    check("mid_rst_dec",    out_dec,   0);
    rst = 1'b0; in_bin = 4'd4; out_ready = 1'b1;
    tick();
    check("post_rst_valid", out_valid, 1);
    check("post_rst_dec",   out_dec,   10'h010);
    in_valid = 1'b0;
    tick();
    check("post_rst_drain", out_valid, 0);

    // Random handshakes against a scoreboard.
    m_err = 0; m_err_sat = 0; pending = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      check("rnd_valid",   out_valid, (sb_q.size() != 0) ? 1 : 0);
      check("rnd_ready",   in_ready,  (sb_q.size() < DEPTH) ? 1 : 0);
      check("rnd_errcnt",  err_cnt,     m_err);
      check("rnd_errcnt2", err_cnt_sat, m_err_sat);
      if (!pending) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_bin   = 4'($urandom_range(0, 15));
      end
      out_ready = 1'($urandom_range(0, 1));
      err_clr   = ($urandom_range(0, 63) == 0);
      push_will = in_valid && in_ready;
      pop_will  = out_valid && out_ready;
      if (pop_will) begin
        if (sb_q.size() == 0) begin
          check("rnd_pop_empty", 1, 0);
        end else begin
          head = sb_q.pop_front();
          check("rnd_dec", out_dec, bin2onehot(head));
          check("rnd_err", out_err, (head > 4'd9) ? 1 : 0);
        end
      end
      if (push_will) sb_q.push_back(in_bin);
      if (err_clr) begin
        m_err = 0; m_err_sat = 0;
      end else if (push_will && in_bin > 4'd9) begin
        if (m_err < 255) m_err++;
        if (m_err_sat < 3) m_err_sat++;
      end
      pending = in_valid && !push_will;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
